// File: rtl/cross_clock_req_sender.sv
`timescale 1ns/1ps
// Source side of a four-phase req/ack crossing: stretches strobes into a held request level,
// waits for the filtered destination ack to rise and fall, and queues at most one strobe.
module cross_clock_req_sender #(
  parameter int HOLD_CYCLES = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic in_stb,
  input  logic in_ack,
  input  logic clr_overflow,
  output logic out_req,
  output logic busy,
  output logic done,
  output logic timeout,
  output logic overflow
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [2:0]    ack_sync_reg, ack_sync_next;
  logic          ack_f_reg, ack_f_next;
  logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
  logic [TW-1:0] wait_cnt_reg, wait_cnt_next;
  logic          pending_reg, pending_next;
  logic          overflow_reg, overflow_next;
  logic          done_reg, timeout_reg;
  logic          out_req_reg, busy_reg;
  logic          hold_met, ack_exit, wait_expired, release_exit;
  logic          strobe_drop, state_entry;

  // Three-stage synchronizer chain for the asynchronous ack
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ack_sync
      if (gi == 0) begin : g_first
        assign ack_sync_next[gi] = in_ack;
      end else begin : g_rest
        assign ack_sync_next[gi] = ack_sync_reg[gi-1];
      end
    end
  endgenerate

  // The level only moves when two consecutive synchronized samples agree
  always_comb begin
    ack_f_next = ack_f_reg;
    if (ack_sync_reg[2:1] == 2'b11) begin
      ack_f_next = 1'b1;
    end else if (ack_sync_reg[2:1] == 2'b00) begin
      ack_f_next = 1'b0;
    end
  end

  assign hold_met     = (hold_cnt_reg == HOLD_LAST);
  assign ack_exit     = (state_reg == ASSERT) && ack_f_reg && hold_met;
  assign wait_expired = TIMEOUT_EN && (state_reg == ASSERT) && !ack_f_reg &&
                        (wait_cnt_reg == WAIT_LAST);
  assign release_exit = (state_reg == RELEASE) && !ack_f_reg && hold_met;

  always_comb begin
    state_next    = state_reg;
    pending_next  = pending_reg;
    overflow_next = overflow_reg;
    strobe_drop   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (in_stb) state_next = ASSERT;
      end
      ASSERT: begin
        if (ack_exit || wait_expired) state_next = RELEASE;
      end
      RELEASE: begin
        if (release_exit) state_next = (pending_reg || in_stb) ? ASSERT : IDLE;
      end
      default: state_next = IDLE;
    endcase

    // On completion one request is consumed; a coincident strobe with a full queue refills it
    if (release_exit) begin
      pending_next = pending_reg & in_stb;
    end else if ((state_reg != IDLE) && in_stb) begin
      if (pending_reg) strobe_drop = 1'b1;
      else             pending_next = 1'b1;
    end

    if (strobe_drop)       overflow_next = 1'b1;
    else if (clr_overflow) overflow_next = 1'b0;
  end

  always_comb begin
    state_entry   = (state_next != state_reg);
    hold_cnt_next = hold_cnt_reg;
    wait_cnt_next = wait_cnt_reg;
    if (state_entry) begin
      hold_cnt_next = '0;
      wait_cnt_next = '0;
    end else begin
      if (!hold_met) hold_cnt_next = hold_cnt_reg + 1'b1;
      if ((state_reg == ASSERT) && (wait_cnt_reg != WAIT_LAST))
        wait_cnt_next = wait_cnt_reg + 1'b1;
    end
  end

  // out_req/busy come straight from flops so the crossing never sees a decode glitch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      ack_sync_reg <= '0;
      ack_f_reg    <= 1'b0;
      hold_cnt_reg <= '0;
      wait_cnt_reg <= '0;
      pending_reg  <= 1'b0;
      overflow_reg <= 1'b0;
      done_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
      out_req_reg  <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ack_sync_reg <= ack_sync_next;
      ack_f_reg    <= ack_f_next;
      hold_cnt_reg <= hold_cnt_next;
      wait_cnt_reg <= wait_cnt_next;
      pending_reg  <= pending_next;
      overflow_reg <= overflow_next;
      done_reg     <= release_exit;
      timeout_reg  <= wait_expired;
      out_req_reg  <= (state_next == ASSERT);
      busy_reg     <= (state_next != IDLE);
    end
  end

  assign out_req  = out_req_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign timeout  = timeout_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_cross_clock_req_sender.sv
`timescale 1ns/1ps
// Bench for cross_clock_req_sender: vector table, directed corner sequences and
// randomized traffic checked every cycle against a handshake-level reference model.
module tb_cross_clock_req_sender;

  localparam int H = 4;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst, in_stb, in_ack, clr_overflow;
  logic out_req, busy, done, timeout, overflow;

  logic       echo_en, ack_man;
  logic [7:0] dly;
  logic [2:0] echo_dly;

  int n_vec = 0;
  int n_err = 0;
  int ndone = 0;
  int cyc   = 0;

  // reference model: request level, phase age, time waiting for ack, queued strobes
  bit m_req, m_busy, m_done, m_to, m_ovf, m_ackf;
  int m_age, m_wait, m_q;
  bit ack_hist[$];

  typedef struct packed {
    logic       stb;
    logic       ack;
    logic       clr;
    logic [4:0] exp;   // {out_req, busy, done, timeout, overflow}
  } vec_t;

  vec_t tbl[$];

  cross_clock_req_sender #(.HOLD_CYCLES(H), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .in_stb(in_stb), .in_ack(in_ack),
    .clr_overflow(clr_overflow), .out_req(out_req), .busy(busy),
    .done(done), .timeout(timeout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // destination that echoes out_req back as ack after a selectable delay
  always @(posedge clk) begin
    if (rst) dly <= '0;
    else     dly <= {dly[6:0], out_req};
  end
  assign in_ack = echo_en ? dly[echo_dly] : ack_man;

  function automatic vec_t mk(input logic s, input logic a, input logic c, input logic [4:0] e);
    vec_t v;
    v.stb = s; v.ack = a; v.clr = c; v.exp = e;
    return v;
  endfunction

  function automatic logic [31:0] outs();
    return {27'd0, out_req, busy, done, timeout, overflow};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_req = 0; m_busy = 0; m_done = 0; m_to = 0; m_ovf = 0; m_ackf = 0;
    m_age = 0; m_wait = 0; m_q = 0;
    ack_hist = {1'b0, 1'b0, 1'b0};
  endtask

  task automatic model_queue(input bit stb, inout bit drop);
    if (stb) begin
      if (m_q == 0) m_q = 1;
      else          drop = 1;
    end
  endtask

  task automatic model_step(input bit stb, input bit ack, input bit clr);
    bit ackf_now, drop;
    int n;
    ackf_now = m_ackf;
    drop = 0;
    m_done = 0;
    m_to = 0;
    if (!m_busy) begin
      if (stb) begin m_busy = 1; m_req = 1; m_age = 0; m_wait = 0; end
    end else if (m_req) begin
      if (ackf_now && m_age >= H-1) begin
        m_req = 0; m_age = 0;
      end else if (T != 0 && !ackf_now && m_wait >= T-1) begin
        m_to = 1; m_req = 0; m_age = 0;
      end else begin
        m_age++; m_wait++;
      end
      model_queue(stb, drop);
    end else begin
      if (!ackf_now && m_age >= H-1) begin
        m_done = 1;
        n = m_q + int'(stb);
        if (n > 0) begin m_req = 1; m_age = 0; m_wait = 0; m_q = n - 1; end
        else begin m_busy = 0; m_q = 0; end
      end else begin
        m_age++;
        model_queue(stb, drop);
      end
    end
    if (drop)     m_ovf = 1;
    else if (clr) m_ovf = 0;
    // filtered ack follows the samples taken two and three edges back when they agree
    if (ack_hist[1] && ack_hist[2])        m_ackf = 1;
    else if (!ack_hist[1] && !ack_hist[2]) m_ackf = 0;
    ack_hist.push_front(ack);
    void'(ack_hist.pop_back());
  endtask

  function automatic bit model_completing();
    return m_busy && !m_req && !m_ackf && (m_age >= H-1);
  endfunction

  task automatic tick();
    bit s, a, c;
    #1;
    s = in_stb; a = in_ack; c = clr_overflow;
    @(posedge clk);
    model_step(s, a, c);
    #1;
    cyc++;
    if (done) ndone++;
    chk("model", outs(), {27'd0, m_req, m_busy, m_done, m_to, m_ovf});
  endtask

  task automatic wait_idle(input int max);
    for (int k = 0; k < max && busy; k++) tick();
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi, lat, mode;
    bit saw;

    // single handshake with a 3-cycle ack echo
    tbl.push_back(mk(1, 0, 0, 5'b11000));
    for (int i = 1; i <= 2; i++)   tbl.push_back(mk(0, 0, 0, 5'b11000));
    for (int i = 3; i <= 6; i++)   tbl.push_back(mk(0, 1, 0, 5'b11000));
    for (int i = 7; i <= 9; i++)   tbl.push_back(mk(0, 1, 0, 5'b01000));
    for (int i = 10; i <= 13; i++) tbl.push_back(mk(0, 0, 0, 5'b01000));
    tbl.push_back(mk(0, 0, 0, 5'b00100));
    tbl.push_back(mk(0, 0, 1, 5'b00000));
    // one-cycle ack glitch is ignored, then the handshake times out
    tbl.push_back(mk(1, 0, 0, 5'b11000));
    tbl.push_back(mk(0, 0, 0, 5'b11000));
    tbl.push_back(mk(0, 1, 0, 5'b11000));
    for (int i = 19; i <= 31; i++) tbl.push_back(mk(0, 0, 0, 5'b11000));
    tbl.push_back(mk(0, 0, 0, 5'b01010));
    for (int i = 33; i <= 35; i++) tbl.push_back(mk(0, 0, 0, 5'b01000));
    tbl.push_back(mk(0, 0, 0, 5'b00100));
    tbl.push_back(mk(0, 0, 0, 5'b00000));

    rst = 1; in_stb = 0; clr_overflow = 0; ack_man = 0; echo_en = 0; echo_dly = 3'd2;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), 32'd0);
    rst = 0;

    for (int i = 0; i < tbl.size(); i++) begin
      in_stb = tbl[i].stb; ack_man = tbl[i].ack; clr_overflow = tbl[i].clr;
      tick();
      chk($sformatf("vec%0d", i), outs(), {27'd0, tbl[i].exp});
    end
    in_stb = 0; ack_man = 0; clr_overflow = 0;

    // ack already high before the strobe
    ack_man = 1;
    repeat (6) tick();
    in_stb = 1; tick(); in_stb = 0;
    hi = out_req ? 1 : 0;
    saw = 0;
    repeat (20) begin
      tick();
      if (out_req) hi++;
      if (done) saw = 1;
    end
    chk("ackhigh_req_cycles", 32'(hi), 32'd4);
    chk("ackhigh_held_release", {30'd0, busy, saw}, 32'b10);
    ack_man = 0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done) begin lat = k; break; end
    end
    chk("ackhigh_done_latency", 32'(lat), 32'd5);
    chk("ackhigh_idle_at_done", 32'(busy), 32'd0);

    // three strobes in one handshake: one queued, one dropped
    echo_en = 1; echo_dly = 3'd2; ndone = 0;
    in_stb = 1; tick(); in_stb = 0; tick();
    in_stb = 1; tick(); in_stb = 0; tick();
    in_stb = 1; tick(); in_stb = 0;
    wait_idle(200);
    chk("two_handshakes", 32'(ndone), 32'd2);
    chk("overflow_set", 32'(overflow), 32'd1);
    clr_overflow = 1; tick(); clr_overflow = 0;
    chk("overflow_cleared", 32'(overflow), 32'd0);

    // strobe on the completion cycle while a request is already queued
    ndone = 0;
    in_stb = 1; tick(); in_stb = 0; tick();
    in_stb = 1; tick(); in_stb = 0;
    for (int k = 0; k < 100 && !model_completing(); k++) tick();
    chk("completion_in_release", {30'd0, busy, out_req}, 32'b10);
    in_stb = 1; tick(); in_stb = 0;
    chk("refill_restart", {29'd0, out_req, done, overflow}, 32'b110);
    wait_idle(300);
    chk("three_handshakes", 32'(ndone), 32'd3);
    chk("no_overflow", 32'(overflow), 32'd0);

    // asynchronous reset in ASSERT with a queued request
    echo_en = 0; ack_man = 0;
    in_stb = 1; tick(); tick(); in_stb = 0; tick();
    #3 rst = 1;
    #1;
    chk("async_reset", {29'd0, out_req, busy, done}, 32'd0);
    model_reset();
    @(posedge clk); @(posedge clk);
    #1 rst = 0;
    ndone = 0; saw = 0;
    repeat (40) begin
      tick();
      if (out_req || busy) saw = 1;
    end
    chk("no_replay_req", 32'(saw), 32'd0);
    chk("no_replay_done", 32'(ndone), 32'd0);

    // randomized traffic under changing destination behaviour
    for (int blk = 0; blk < 30; blk++) begin
      mode = $urandom_range(0, 3);
      echo_en = (mode == 0);
      echo_dly = 3'($urandom_range(0, 7));
      ack_man = (mode == 2);
      for (int j = 0; j < 100; j++) begin
        in_stb = ($urandom_range(0, 6) == 0);
        clr_overflow = ($urandom_range(0, 19) == 0);
        if (mode == 3) ack_man = ($urandom_range(0, 2) != 0);
        tick();
      end
    end
    in_stb = 0; clr_overflow = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
